// File: rtl/instr_fetch_decode.sv
// Instruction fetch + decode: drives the synchronous ROM, absorbs its 1-cycle latency
// with a 2-entry buffer, and hands decoded RV32 fields to the pipeline over valid/ready.
module instr_fetch_decode #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_instr,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [2:0]        out_class,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic [31:0]       out_imm,
    output logic              out_illegal
);

    localparam logic [2:0] CLS_R      = 3'd0;
    localparam logic [2:0] CLS_I_IMM  = 3'd1;
    localparam logic [2:0] CLS_LOAD   = 3'd2;
    localparam logic [2:0] CLS_STORE  = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;
    localparam logic [2:0] CLS_JAL    = 3'd5;
    localparam logic [2:0] CLS_ILL    = 3'd7;

    typedef enum logic {RUN, FLUSH} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  cls;
        logic [31:0] imm;
    } entry_t;

    function automatic entry_t decode(input logic [31:0] i, input logic [31:0] pc);
        entry_t     e;
        logic [2:0] f3;
        logic [6:0] f7;
        f3      = i[14:12];
        f7      = i[31:25];
        e.pc    = pc;
        e.instr = i;
        e.cls   = CLS_ILL;
        e.imm   = '0;
        case (i[6:0])
            7'b0110011: begin
                if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))
                    e.cls = CLS_R;
            end
            7'b0010011: begin
                e.cls = CLS_I_IMM;
                e.imm = {{20{i[31]}}, i[31:20]};
            end
            7'b0000011: begin
                if (f3 == 3'b010) begin
                    e.cls = CLS_LOAD;
                    e.imm = {{20{i[31]}}, i[31:20]};
                end
            end
            7'b0100011: begin
                if (f3 == 3'b010) begin
                    e.cls = CLS_STORE;
                    e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
                end
            end
            7'b1100011: begin
                if (f3 != 3'd2 && f3 != 3'd3) begin
                    e.cls = CLS_BRANCH;
                    e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                end
            end
            7'b1101111: begin
                e.cls = CLS_JAL;
                e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            default: ;
        endcase
        return e;
    endfunction

    state_t            state, state_d;
    logic [31:0]       pc, inflight_pc;
    logic              inflight;
    entry_t [1:0]      fifo;
    logic              head;
    logic [1:0]        count;
    logic              pop, push, fire;
    logic [2:0]        occ;
    logic              tail;
    entry_t            hd;

    assign rom_addr  = pc[ADDR_W+1:2];
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign tail      = head ^ count[0];
    assign hd        = fifo[head];

    // FLUSH only blocks capture of a stale ROM word; the target fetch starts right away.
    always_comb begin
        state_d = state;
        push    = 1'b0;
        occ     = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
        fire    = !redirect_valid && (occ < 3'd2);
        if (redirect_valid) begin
            state_d = FLUSH;
        end else begin
            case (state)
                RUN:     push = inflight;
                FLUSH:   state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            fifo        <= '0;
            head        <= 1'b0;
            count       <= 2'd0;
        end else begin
            state <= state_d;
            if (redirect_valid) begin
                pc       <= redirect_pc & ~32'd3;
                inflight <= 1'b0;
                head     <= 1'b0;
                count    <= 2'd0;
            end else begin
                inflight <= fire;
                if (fire) begin
                    inflight_pc <= pc;
                    pc          <= pc + 32'd4;
                end
                if (push)
                    fifo[tail] <= decode(rom_instr, inflight_pc);
                if (pop)
                    head <= ~head;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    // Data outputs read as zero whenever nothing is presented.
    always_comb begin
        out_pc      = '0;
        out_instr   = '0;
        out_class   = '0;
        out_imm     = '0;
        out_illegal = 1'b0;
        if (out_valid) begin
            out_pc      = hd.pc;
            out_instr   = hd.instr;
            out_class   = hd.cls;
            out_imm     = hd.imm;
            out_illegal = (hd.cls == CLS_ILL);
        end
    end

    assign out_rd     = out_instr[11:7];
    assign out_rs1    = out_instr[19:15];
    assign out_rs2    = out_instr[24:20];
    assign out_funct3 = out_instr[14:12];
    assign out_funct7 = out_instr[31:25];

endmodule
